// File: rtl/obi_demux_outstanding.sv
// 1-to-N OBI demultiplexer with outstanding-transaction tracking and in-order response routing.
// Define OBI_DEMUX_ERR_RESP_EN to answer unmapped addresses from an internal error responder.

package obi_demux_outstanding_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

endpackage

module obi_demux_outstanding
  import obi_demux_outstanding_pkg::*;
#(
  parameter int unsigned NUM_SLAVES      = 2,
  parameter int unsigned NUM_RULES       = 1,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1),
  parameter int unsigned IDX_W           = $clog2(NUM_SLAVES)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  addr_map_rule_t [NUM_RULES-1:0]  addr_map_i,
  input  logic [IDX_W-1:0]                default_idx_i,
  input  obi_req_t                        master_req_i,
  output obi_resp_t                       master_resp_o,
  output obi_req_t [NUM_SLAVES-1:0]       slave_req_o,
  input  obi_resp_t [NUM_SLAVES-1:0]      slave_resp_i,
  output logic [CNT_W-1:0]                outstanding_o
);

`ifdef OBI_DEMUX_ERR_RESP_EN
  // The error responder occupies the virtual target index NUM_SLAVES.
  localparam int unsigned TGT_W = $clog2(NUM_SLAVES + 1);
  localparam logic [TGT_W-1:0] ERR_IDX = TGT_W'(NUM_SLAVES);
`else
  localparam int unsigned TGT_W = IDX_W;
`endif

  logic [CNT_W-1:0] cnt;
  logic [TGT_W-1:0] cur_idx;
  logic [TGT_W-1:0] dec_idx;
  logic [TGT_W-1:0] rule_idx;
  logic             rule_hit;
  logic             allow;
  logic             sel_gnt;
  logic             gnt_int;
  logic             accept;
  logic             rsp_rvalid;
  logic [31:0]      rsp_rdata;
  logic             rvalid_fwd;

`ifdef OBI_DEMUX_ERR_RESP_EN
  logic             err_pend;
`endif

  // Scan from the highest rule down so the lowest-numbered match wins.
  always_comb begin
    rule_hit = 1'b0;
    rule_idx = '0;
    for (int r = int'(NUM_RULES) - 1; r >= 0; r--) begin
      if ((addr_map_i[r].idx < NUM_SLAVES) &&
          (master_req_i.addr >= addr_map_i[r].start_addr) &&
          (master_req_i.addr <  addr_map_i[r].end_addr)) begin
        rule_hit = 1'b1;
        rule_idx = TGT_W'(addr_map_i[r].idx);
      end
    end
  end

`ifdef OBI_DEMUX_ERR_RESP_EN
  assign dec_idx = rule_hit ? rule_idx : ERR_IDX;
`else
  assign dec_idx = rule_hit ? rule_idx : TGT_W'(default_idx_i);
`endif

  // A new target is only accepted once every response from the old one has drained.
  assign allow = (cnt < CNT_W'(MAX_OUTSTANDING)) &&
                 ((cnt == '0) || (dec_idx == cur_idx));

  always_comb begin
    sel_gnt    = 1'b0;
    rsp_rvalid = 1'b0;
    rsp_rdata  = '0;
    for (int s = 0; s < int'(NUM_SLAVES); s++) begin
      if (dec_idx == TGT_W'(s)) begin
        sel_gnt = slave_resp_i[s].gnt;
      end
      if (cur_idx == TGT_W'(s)) begin
        rsp_rvalid = slave_resp_i[s].rvalid;
        rsp_rdata  = slave_resp_i[s].rdata;
      end
    end
`ifdef OBI_DEMUX_ERR_RESP_EN
    if (dec_idx == ERR_IDX) begin
      sel_gnt = 1'b1;
    end
    if (cur_idx == ERR_IDX) begin
      rsp_rvalid = err_pend;
      rsp_rdata  = 32'hBADACCE5;
    end
`endif
  end

  always_comb begin
    for (int s = 0; s < int'(NUM_SLAVES); s++) begin
      slave_req_o[s] = '0;
      if (dec_idx == TGT_W'(s)) begin
        slave_req_o[s]     = master_req_i;
        slave_req_o[s].req = master_req_i.req && allow;
      end
    end
  end

  assign gnt_int    = allow && sel_gnt;
  assign accept     = master_req_i.req && gnt_int;
  assign rvalid_fwd = rsp_rvalid && (cnt != '0);

  // Upstream response stays silent while the reset is held.
  assign master_resp_o.gnt    = rst_ni && gnt_int;
  assign master_resp_o.rvalid = rst_ni && rvalid_fwd;
  assign master_resp_o.rdata  = (rst_ni && rvalid_fwd) ? rsp_rdata : '0;
  assign outstanding_o        = cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt      <= '0;
      cur_idx  <= '0;
`ifdef OBI_DEMUX_ERR_RESP_EN
      err_pend <= 1'b0;
`endif
    end else begin
      if (accept && !rvalid_fwd) begin
        cnt <= cnt + CNT_W'(1);
      end else if (!accept && rvalid_fwd) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (accept) begin
        cur_idx <= dec_idx;
      end
`ifdef OBI_DEMUX_ERR_RESP_EN
      err_pend <= accept && (dec_idx == ERR_IDX);
`endif
    end
  end

  a_no_idle_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_rvalid |-> (cnt != '0));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    accept |-> (cnt < CNT_W'(MAX_OUTSTANDING)));

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_rvalid_chk
    a_rvalid_from_cur: assert property (@(posedge clk_i) disable iff (!rst_ni)
      slave_resp_i[s].rvalid |-> ((cnt != '0) && (cur_idx == TGT_W'(s))));
  end

endmodule
